// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: FSM states and shared constants for the frame sequencer
package frame_sequencer_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_MOVE} state_t;
    localparam int NUM_CLIENTS = 3;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [1:0] CL_PLAT = 2'd0;
    localparam logic [1:0] CL_BALL = 2'd1;
    localparam logic [1:0] CL_BRICK = 2'd2;
endpackage

// File: rtl/frame_sequencer_timer.sv
// frame_timer: free-running frame down-counter producing a one-cycle frame_tick
// ports: clk, resetn (async, active-low) in; frame_tick out (high while count is 0)
module frame_timer #(
    parameter int FRAME_CYCLES = 833334
) (
    input  logic clk,
    input  logic resetn,
    output logic frame_tick
);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        frame_tick = cnt_q == '0;
        cnt_d = frame_tick ? LAST : cnt_q - 1'b1;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt_q <= LAST;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame erase/move/redraw scheduler and VGA pixel multiplexer
// ports: clk, resetn (async, active-low), pause, cN_x/cN_y/cN_colour/cN_wren from the
// platform(0)/ball(1)/bricks(2) drawers; draw/move requests to them; registered
// vga_x/vga_y/vga_colour/vga_plot; frame_tick, busy and sticky overrun status
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_CYCLES = 833334,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   pause,
    input  logic [9:0]             c0_x,
    input  logic [9:0]             c0_y,
    input  logic [2:0]             c0_colour,
    input  logic                   c0_wren,
    input  logic [9:0]             c1_x,
    input  logic [9:0]             c1_y,
    input  logic [2:0]             c1_colour,
    input  logic                   c1_wren,
    input  logic [9:0]             c2_x,
    input  logic [9:0]             c2_y,
    input  logic [2:0]             c2_colour,
    input  logic                   c2_wren,
    output logic [NUM_CLIENTS-1:0] draw,
    output logic                   move,
    output logic [9:0]             vga_x,
    output logic [9:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   frame_tick,
    output logic                   busy,
    output logic                   overrun
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic erase_q, erase_d, seen_q, seen_d, overrun_q, overrun_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [9:0] vga_x_q, vga_x_d, vga_y_q, vga_y_d, sel_x, sel_y;
    logic [2:0] vga_colour_q, vga_colour_d, sel_colour;
    logic vga_plot_q, vga_plot_d, sel_wren, in_wait, done;

    frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
        .clk(clk),
        .resetn(resetn),
        .frame_tick(frame_tick)
    );

    always_comb begin
        sel_x = idx_q == CL_PLAT ? c0_x : idx_q == CL_BALL ? c1_x : c2_x;
        sel_y = idx_q == CL_PLAT ? c0_y : idx_q == CL_BALL ? c1_y : c2_y;
        sel_colour = idx_q == CL_PLAT ? c0_colour : idx_q == CL_BALL ? c1_colour : c2_colour;
        sel_wren = idx_q == CL_PLAT ? c0_wren : idx_q == CL_BALL ? c1_wren : c2_wren;
        // a client only finishes after it has actually written, so an early low wren is ignored
        done = (seen_q & ~sel_wren) | (tcnt_q == T_LAST);
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q <= CL_PLAT;
            erase_q <= 1'b0;
            seen_q <= 1'b0;
            tcnt_q <= '0;
            overrun_q <= 1'b0;
            vga_x_q <= '0;
            vga_y_q <= '0;
            vga_colour_q <= BLACK;
            vga_plot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            erase_q <= erase_d;
            seen_q <= seen_d;
            tcnt_q <= tcnt_d;
            overrun_q <= overrun_d;
            vga_x_q <= vga_x_d;
            vga_y_q <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q <= vga_plot_d;
        end

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        erase_d = erase_q;
        seen_d = seen_q;
        tcnt_d = tcnt_q;
        overrun_d = overrun_q | (frame_tick & (state_q != S_IDLE));
        case (state_q)
            S_IDLE:
                if (frame_tick & ~pause) begin
                    idx_d = CL_PLAT;
                    erase_d = 1'b1;
                    state_d = S_REQ;
                end
            S_REQ: begin
                seen_d = 1'b0;
                tcnt_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                seen_d = seen_q | sel_wren;
                tcnt_d = tcnt_q + 1'b1;
                if (done) begin
                    idx_d = idx_q == CL_BRICK ? CL_PLAT : idx_q + 1'b1;
                    state_d = idx_q != CL_BRICK ? S_REQ : erase_q ? S_MOVE : S_IDLE;
                end
            end
            S_MOVE: begin
                erase_d = 1'b0;
                idx_d = CL_PLAT;
                state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_wait = state_q == S_WAIT;
        draw = state_q == S_REQ ? NUM_CLIENTS'(1) << idx_q : '0;
        move = state_q == S_MOVE;
        busy = state_q != S_IDLE;
        vga_plot_d = in_wait & sel_wren;
        vga_x_d = in_wait ? sel_x : '0;
        vga_y_d = in_wait ? sel_y : '0;
        vga_colour_d = (!in_wait || erase_q) ? BLACK : sel_colour;
        vga_x = vga_x_q;
        vga_y = vga_y_q;
        vga_colour = vga_colour_q;
        vga_plot = vga_plot_q;
        overrun = overrun_q;
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized clients checked against a per-pass schedule model
module tb_frame_sequencer;
    localparam int F = 300;
    localparam int TO = 50;
    localparam int NC = 4096;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pause = 1'b0;
    logic [9:0] c_x[3], c_y[3];
    logic [2:0] c_col[3];
    logic [2:0] c_wren;
    logic [2:0] draw, vga_colour;
    logic move, frame_tick, busy, overrun, vga_plot;
    logic [9:0] vga_x, vga_y;
    int n_chk = 0, n_bad = 0, cyc = 0;
    bit [2:0] e_draw[NC];
    bit e_move[NC], e_busy[NC], e_plot[NC];
    logic [9:0] e_x[NC], e_y[NC];
    logic [2:0] e_col[NC];
    int m_end, ovr_from, mode;
    bit noise, rand_pause;
    int pd[3], pl[3], cd[3];
    logic [9:0] px[3], py[3];
    logic [2:0] pc[3];

    frame_sequencer #(.FRAME_CYCLES(F), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .pause(pause),
        .c0_x(c_x[0]), .c0_y(c_y[0]), .c0_colour(c_col[0]), .c0_wren(c_wren[0]),
        .c1_x(c_x[1]), .c1_y(c_y[1]), .c1_colour(c_col[1]), .c1_wren(c_wren[1]),
        .c2_x(c_x[2]), .c2_y(c_y[2]), .c2_colour(c_col[2]), .c2_wren(c_wren[2]),
        .draw(draw), .move(move), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .frame_tick(frame_tick),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic pick_profiles();
        for (int i = 0; i < 3; i++) begin
            pd[i] = $urandom_range(1, 6);
            pl[i] = (mode == 0 || $urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
            px[i] = 10'($urandom_range(0, 900));
            py[i] = 10'($urandom_range(0, 1000));
            pc[i] = 3'($urandom_range(1, 7));
        end
        if (mode == 1) begin
            pd[0] = 2; pl[0] = 12; px[0] = 10'd32; py[0] = 10'd220; pc[0] = 3'b100;
        end
    endtask

    // lay out a whole pass: erase slots 0..2, move, draw slots 0..2
    task automatic schedule(input int tick);
        int t;
        t = tick + 1;
        for (int s = 0; s < 7; s++) begin
            if (s == 3) begin
                e_move[t] = 1; e_busy[t] = 1; t++;
            end else begin
                int n;
                int len;
                n = s < 3 ? s : s - 4;
                len = (pl[n] > 0 && pd[n] + pl[n] < TO) ? pd[n] + pl[n] : TO;
                e_draw[t] = 3'(1 << n);
                for (int k = t; k <= t + len; k++) e_busy[k] = 1;
                for (int k = 0; k < pl[n]; k++)
                    if (pd[n] + k <= TO) begin
                        int w;
                        w = t + pd[n] + k;
                        e_plot[w+1] = 1;
                        e_x[w+1] = px[n] + 10'(k);
                        e_y[w+1] = py[n];
                        e_col[w+1] = s < 3 ? 3'b000 : pc[n];
                    end
                t = t + len + 1;
            end
        end
        m_end = t - 1;
    endtask

    task automatic do_reset();
        resetn = 0;
        pause = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic run_phase(input int ncyc, input bit mid_reset);
        bit armed, hit;
        armed = 0;
        hit = 0;
        for (int i = 0; i < NC; i++) begin
            e_draw[i] = 0; e_move[i] = 0; e_busy[i] = 0; e_plot[i] = 0;
        end
        m_end = -1;
        ovr_from = NC * 2;
        cd = '{-1000, -1000, -1000};
        for (int c = 0; c < ncyc && !hit; c++) begin
            cyc = c;
            if (mode == 1) pause = (c >= 320 && c < 380) || (c >= 880 && c < 920);
            else if (rand_pause && $urandom_range(0, 63) == 0) pause = !pause;
            if (c % F == F - 1) begin
                if (c <= m_end) begin
                    if (ovr_from > c) ovr_from = c + 1;
                end else if (!pause) begin
                    pick_profiles();
                    schedule(c);
                end
            end
            chk("tick", 32'(frame_tick), 32'(c % F == F - 1));
            chk("draw", 32'(draw), 32'(e_draw[c]));
            chk("move", 32'(move), 32'(e_move[c]));
            chk("busy", 32'(busy), 32'(e_busy[c]));
            chk("overrun", 32'(overrun), 32'(c >= ovr_from));
            chk("plot", 32'(vga_plot), 32'(e_plot[c]));
            if (e_plot[c]) begin
                chk("vga_x", 32'(vga_x), 32'(e_x[c]));
                chk("vga_y", 32'(vga_y), 32'(e_y[c]));
                chk("vga_colour", 32'(vga_colour), 32'(e_col[c]));
            end
            for (int i = 0; i < 3; i++) begin
                if (draw[i]) cd[i] = c;
                if (c > cd[i] && c <= cd[i] + TO) begin
                    c_wren[i] = c >= cd[i] + pd[i] && c < cd[i] + pd[i] + pl[i];
                    c_x[i] = px[i] + 10'(c - cd[i] - pd[i]);
                    c_y[i] = py[i];
                    c_col[i] = pc[i];
                end else begin
                    c_wren[i] = noise && $urandom_range(0, 3) == 0;
                    c_x[i] = 10'($urandom);
                    c_y[i] = 10'($urandom);
                    c_col[i] = 3'($urandom);
                end
            end
            if (mid_reset && armed) begin
                resetn = 0;
                #1;
                chk("rst_draw", 32'(draw), 0);
                chk("rst_move", 32'(move), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_plot", 32'(vga_plot), 0);
                chk("rst_xy", {12'd0, vga_x, vga_y}, 0);
                chk("rst_colour", 32'(vga_colour), 0);
                chk("rst_overrun", 32'(overrun), 0);
                chk("rst_tick", 32'(frame_tick), 0);
                hit = 1;
                @(negedge clk);
                resetn = 1;
            end else begin
                if (mid_reset && draw[1]) armed = 1;
                @(negedge clk);
            end
        end
        if (mid_reset) chk("ball_slot_reached", 32'(hit), 1);
    endtask

    initial begin
        c_wren = '0;
        for (int i = 0; i < 3; i++) begin
            c_x[i] = '0; c_y[i] = '0; c_col[i] = '0;
        end
        mode = 0; noise = 0; rand_pause = 0;
        do_reset();
        run_phase(700, 0);
        mode = 1; noise = 1;
        do_reset();
        run_phase(2000, 0);
        mode = 2;
        do_reset();
        run_phase(600, 1);
        rand_pause = 1;
        run_phase(2400, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
